// File: rtl/core_dmem_pmp_gate.sv
// Data-side PMP gate between the LSU and the data memory bus.
// Optional misalignment faulting: define CORE_DMEM_MISALIGN_CHECK_EN.
module core_dmem_pmp_gate #(
  parameter int ADDR_WIDTH      = 56,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  cpu_req,
  output logic                  cpu_gnt,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_wen,
  input  logic [7:0]            cpu_strb,
  input  logic [63:0]           cpu_wdata,
  input  logic [1:0]            cpu_prv,
  input  logic [1:0]            cpu_size,
  output logic                  cpu_rsp_valid,
  output logic                  cpu_rsp_error,
  output logic                  cpu_rsp_misalign,
  output logic [63:0]           cpu_rsp_rdata,
  output logic [ADDR_WIDTH-1:0] pmp_addr,
  output logic [1:0]            pmp_prv,
  output logic                  pmp_wen,
  output logic                  pmp_req,
  input  logic                  pmp_trap,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [7:0]            mem_strb,
  output logic [63:0]           mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic                  mem_rsp_error,
  input  logic [63:0]           mem_rsp_rdata
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err_pend;
  logic          w_mis;
  logic          w_fault;
  logic          w_full;
  logic          w_idle;
  logic          w_local;
  logic          w_inc;
  logic          w_dec;

  assign pmp_addr = cpu_addr;
  assign pmp_prv  = cpu_prv;
  assign pmp_wen  = cpu_wen;
  assign pmp_req  = cpu_req;

  assign mem_addr  = cpu_addr;
  assign mem_wen   = cpu_wen;
  assign mem_strb  = cpu_strb;
  assign mem_wdata = cpu_wdata;

`ifdef CORE_DMEM_MISALIGN_CHECK_EN
  logic [2:0] w_mask;
  logic       r_err_mis;

  always_comb begin
    unique case (cpu_size)
      2'b00:   w_mask = 3'b000;
      2'b01:   w_mask = 3'b001;
      2'b10:   w_mask = 3'b011;
      default: w_mask = 3'b111;
    endcase
  end

  assign w_mis = cpu_req && ((cpu_addr[2:0] & w_mask) != 3'b000);

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) r_err_mis <= 1'b0;
    else         r_err_mis <= w_local && w_mis;
  end

  assign cpu_rsp_misalign = !g_reset && r_err_pend && r_err_mis;
`else
  logic w_unused_size;
  assign w_unused_size    = ^cpu_size;
  assign w_mis            = 1'b0;
  assign cpu_rsp_misalign = 1'b0;
`endif

  assign w_fault = pmp_trap || w_mis;
  // Full is judged on the registered count, so a same-cycle response
  // never frees a slot for a same-cycle grant.
  assign w_full  = (r_cnt >= CW'(MAX_OUTSTANDING));
  assign w_idle  = (r_cnt == '0) && !r_err_pend;

  assign mem_req = !g_reset && cpu_req && !w_fault
                && !r_err_pend && !w_full;
  // Faults wait for the bus to drain so responses stay in order.
  assign w_local = !g_reset && cpu_req && w_fault && w_idle;
  assign w_inc   = mem_req && mem_gnt;
  assign w_dec   = !g_reset && mem_rsp_valid && (r_cnt != '0);

  assign cpu_gnt = w_inc || w_local;

  assign cpu_rsp_valid = !g_reset && (r_err_pend || w_dec);
  assign cpu_rsp_error = !g_reset
                      && (r_err_pend || (w_dec && mem_rsp_error));
  assign cpu_rsp_rdata = w_dec ? mem_rsp_rdata : 64'd0;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_cnt      <= '0;
      r_err_pend <= 1'b0;
    end else begin
      r_err_pend <= w_local;
      unique case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
